// File: rtl/pow_n_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// pow_n_pipe_arbiter
//
// Shares one external arg^n pipeline (fixed latency n, no stall) among NREQ
// requesters. A round-robin arbiter accepts at most one request per cycle
// and issues it to the pipeline. The requester index travels alongside the
// operand in an n-deep tag delay line, so the pipeline result can be routed
// back to the requester that asked for it. Each requester may have up to
// MAXOUT requests in flight. A sticky error flag records any cycle where
// the tag line and the pipeline disagree about whether a result is due.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req_vld       per-requester request valid
//   req_arg       requester k's operand in bits [k*w +: w]
//   req_rdy       per-requester accept (at most one bit high)
//   pipe_arg_vld  issue strobe to the pipeline (combinational)
//   pipe_arg      operand to the pipeline (0 when not issuing)
//   pipe_res_vld  pipeline result valid
//   pipe_res      pipeline result arg^n mod 2^w
//   rsp_vld       registered one-hot response strobe
//   rsp_res       registered response data, holds between responses
//   err           sticky tag/valid mismatch flag
// ---------------------------------------------------------------------------
module pow_n_pipe_arbiter #(
    parameter int w      = 8,
    parameter int n      = 5,
    parameter int NREQ   = 4,
    parameter int MAXOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [NREQ*w-1:0] req_arg,
    output logic [NREQ-1:0]   req_rdy,
    output logic              pipe_arg_vld,
    output logic [w-1:0]      pipe_arg,
    input  logic              pipe_res_vld,
    input  logic [w-1:0]      pipe_res,
    output logic [NREQ-1:0]   rsp_vld,
    output logic [w-1:0]      rsp_res,
    output logic              err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;

    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       ptr_d;
    logic [CW-1:0]       outstanding_q [NREQ];
    logic [n-1:0]        tagVld_q;
    logic [IW-1:0]       tagIdx_q [n];
    logic [NREQ-1:0]     rspVld_q;
    logic [w-1:0]        rspRes_q;
    logic                err_q;

    logic [NREQ-1:0]     eligible;
    logic                grantAny;
    logic [IW-1:0]       grantIdx;
    logic                tagOutVld;
    logic [IW-1:0]       tagOutIdx;

    // A requester may be granted only while it is asking and still has
    // room for another request in flight.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NREQ; k++) begin
            eligible[k] = req_vld[k] && (outstanding_q[k] < CW'(MAXOUT));
        end
    end

    // Round-robin search: walk the requesters starting at the pointer and
    // take the first eligible one. Reset suppresses any grant so nothing is
    // accepted or issued while the block is being cleared.
    always_comb begin
        int cand;
        grantAny = 1'b0;
        grantIdx = '0;
        cand     = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_q) + i) % NREQ;
            if (!grantAny && eligible[cand]) begin
                grantAny = 1'b1;
                grantIdx = IW'(cand);
            end
        end
        if (rst) begin
            grantAny = 1'b0;
        end
    end

    // Accept strobe back to the winner plus the issue towards the pipeline,
    // both in the same cycle as the grant. The pointer moves just past the
    // winner so it becomes lowest priority next time.
    always_comb begin
        req_rdy      = '0;
        pipe_arg_vld = grantAny;
        pipe_arg     = '0;
        ptr_d        = ptr_q;
        if (grantAny) begin
            req_rdy[grantIdx] = 1'b1;
            pipe_arg          = req_arg[grantIdx*w +: w];
            ptr_d             = (grantIdx == IW'(NREQ-1)) ? '0 : grantIdx + IW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Tag delay line: {valid, requester} shifted once per cycle so that the
    // last stage lines up with the pipeline's result for the same issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagVld_q <= '0;
            for (int s = 0; s < n; s++) begin
                tagIdx_q[s] <= '0;
            end
        end else begin
            tagVld_q[0] <= grantAny;
            tagIdx_q[0] <= grantIdx;
            for (int s = 1; s < n; s++) begin
                tagVld_q[s] <= tagVld_q[s-1];
                tagIdx_q[s] <= tagIdx_q[s-1];
            end
        end
    end

    assign tagOutVld = tagVld_q[n-1];
    assign tagOutIdx = tagIdx_q[n-1];

    // Response register: route the pipeline result to the tagged requester.
    // The data register only loads on a real response, so it holds between
    // responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspVld_q <= '0;
            rspRes_q <= '0;
        end else begin
            rspVld_q <= tagOutVld ? (NREQ'(1) << tagOutIdx) : '0;
            if (tagOutVld) begin
                rspRes_q <= pipe_res;
            end
        end
    end

    // In-flight counters. A grant adds one and a delivered response removes
    // one; both in the same cycle cancel. The eligibility check keeps each
    // count from ever going past MAXOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREQ; k++) begin
                outstanding_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (grantAny && (grantIdx == IW'(k)) && !rspVld_q[k]) begin
                    outstanding_q[k] <= outstanding_q[k] + CW'(1);
                end else if (rspVld_q[k] && !(grantAny && (grantIdx == IW'(k)))) begin
                    outstanding_q[k] <= outstanding_q[k] - CW'(1);
                end
            end
        end
    end

    // Sticky error: the pipeline produced a result with no tag waiting for
    // it, or a tag came due with no result. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tagOutVld != pipe_res_vld) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_vld = rspVld_q;
    assign rsp_res = rspRes_q;
    assign err     = err_q;

endmodule

// File: tb/tb_pow_n_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pow_n_pipe_arbiter
//
// Directed bench for pow_n_pipe_arbiter. A behavioural n-stage arg^n
// pipeline sits on the pipe_* ports; an extra inject strobe can force a
// stray pipe_res_vld. Inputs change 1 time unit after the rising edge and
// outputs are sampled shortly after that, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_pow_n_pipe_arbiter;

    localparam int W      = 8;
    localparam int N      = 5;
    localparam int NREQ   = 4;
    localparam int MAXOUT = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*W-1:0] req_arg;
    logic [NREQ-1:0]   req_rdy;
    logic              pipe_arg_vld;
    logic [W-1:0]      pipe_arg;
    logic              pipe_res_vld;
    logic [W-1:0]      pipe_res;
    logic [NREQ-1:0]   rsp_vld;
    logic [W-1:0]      rsp_res;
    logic              err;

    logic              injectVld;
    logic [N-1:0]      mVld;
    logic [W-1:0]      mData [N];

    int vectorCount;
    int miscompareCount;

    pow_n_pipe_arbiter #(
        .w(W), .n(N), .NREQ(NREQ), .MAXOUT(MAXOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_vld(req_vld),
        .req_arg(req_arg),
        .req_rdy(req_rdy),
        .pipe_arg_vld(pipe_arg_vld),
        .pipe_arg(pipe_arg),
        .pipe_res_vld(pipe_res_vld),
        .pipe_res(pipe_res),
        .rsp_vld(rsp_vld),
        .rsp_res(rsp_res),
        .err(err)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arg^N truncated to W bits, as the real pipeline would produce.
    function automatic logic [W-1:0] powN(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = 1;
        for (int i = 0; i < N; i++) begin
            r = r * a;
        end
        return r;
    endfunction

    // Behavioural pipeline: fixed N-cycle latency, flushed by reset like
    // the real pipeline sharing the same reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mVld <= '0;
            for (int s = 0; s < N; s++) begin
                mData[s] <= '0;
            end
        end else begin
            mVld     <= {mVld[N-2:0], pipe_arg_vld};
            mData[0] <= powN(pipe_arg);
            for (int s = 1; s < N; s++) begin
                mData[s] <= mData[s-1];
            end
        end
    end

    assign pipe_res_vld = mVld[N-1] | injectVld;
    assign pipe_res     = mData[N-1];

    // Single comparison point: counts every vector and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the request inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] vld, input logic [7:0] a0,
                                 input logic [7:0] a1, input logic [7:0] a2,
                                 input logic [7:0] a3);
        req_vld = vld;
        req_arg = {a3, a2, a1, a0};
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset pulse with the requests idle.
    task automatic doReset();
        applyStimulus(4'b0000, 0, 0, 0, 0);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences with hand-computed expectations.
    initial begin
        logic [3:0] expRsp [14];
        logic [7:0] expRes [14];
        logic [13:0] expRdy;
        int idx;

        vectorCount     = 0;
        miscompareCount = 0;
        rst       = 1'b1;
        injectVld = 1'b0;
        req_vld   = '0;
        req_arg   = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, with every requester asking.
        applyStimulus(4'b1111, 1, 2, 3, 4);
        checkOutput("rst_rdy", 32'(req_rdy), 0);
        checkOutput("rst_issue", 32'(pipe_arg_vld), 0);
        checkOutput("rst_rsp_vld", 32'(rsp_vld), 0);
        checkOutput("rst_rsp_res", 32'(rsp_res), 0);
        checkOutput("rst_err", 32'(err), 0);
        applyStimulus(4'b0000, 0, 0, 0, 0);
        rst = 1'b0;
        nextCycle();

        // Single transfer, 3^5 = 243 after n+1 cycles.
        applyStimulus(4'b0001, 3, 0, 0, 0);
        checkOutput("t1_rdy", 32'(req_rdy), 32'b0001);
        checkOutput("t1_issue", 32'(pipe_arg_vld), 1);
        checkOutput("t1_arg", 32'(pipe_arg), 3);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            applyStimulus(4'b0000, 0, 0, 0, 0);
            checkOutput("t1_quiet", 32'(rsp_vld), 0);
        end
        nextCycle();
        checkOutput("t1_rsp_vld", 32'(rsp_vld), 32'b0001);
        checkOutput("t1_rsp_res", 32'(rsp_res), 243);
        checkOutput("t1_err", 32'(err), 0);
        nextCycle();
        checkOutput("t1_rsp_drop", 32'(rsp_vld), 0);
        checkOutput("t1_rsp_hold", 32'(rsp_res), 243);

        // Round robin from ptr=0: req0 then req2, then ptr=3 favours req3.
        doReset();
        applyStimulus(4'b0101, 2, 0, 5, 0);
        checkOutput("t2_rdy0", 32'(req_rdy), 32'b0001);
        checkOutput("t2_arg0", 32'(pipe_arg), 2);
        nextCycle();
        applyStimulus(4'b0100, 0, 0, 5, 0);
        checkOutput("t2_rdy2", 32'(req_rdy), 32'b0100);
        checkOutput("t2_arg2", 32'(pipe_arg), 5);
        nextCycle();
        applyStimulus(4'b1001, 3, 0, 0, 1);
        checkOutput("t2_rdy3", 32'(req_rdy), 32'b1000);
        checkOutput("t2_arg3", 32'(pipe_arg), 1);
        repeat (4) begin
            nextCycle();
            applyStimulus(4'b0000, 0, 0, 0, 0);
        end
        checkOutput("t2_rsp0_vld", 32'(rsp_vld), 32'b0001);
        checkOutput("t2_rsp0_res", 32'(rsp_res), 32);
        nextCycle();
        checkOutput("t2_rsp2_vld", 32'(rsp_vld), 32'b0100);
        checkOutput("t2_rsp2_res", 32'(rsp_res), 53);
        nextCycle();
        checkOutput("t2_rsp3_vld", 32'(rsp_vld), 32'b1000);
        checkOutput("t2_rsp3_res", 32'(rsp_res), 1);
        checkOutput("t2_err", 32'(err), 0);

        // Wrap-around results: 4^5 mod 256 = 0, 255^5 mod 256 = 255.
        nextCycle();
        applyStimulus(4'b0010, 0, 4, 0, 0);
        checkOutput("t3_rdy_a", 32'(req_rdy), 32'b0010);
        nextCycle();
        applyStimulus(4'b0010, 0, 255, 0, 0);
        checkOutput("t3_rdy_b", 32'(req_rdy), 32'b0010);
        checkOutput("t3_arg_b", 32'(pipe_arg), 255);
        repeat (5) begin
            nextCycle();
            applyStimulus(4'b0000, 0, 0, 0, 0);
        end
        checkOutput("t3_rsp_a_vld", 32'(rsp_vld), 32'b0010);
        checkOutput("t3_rsp_a_res", 32'(rsp_res), 0);
        nextCycle();
        checkOutput("t3_rsp_b_vld", 32'(rsp_vld), 32'b0010);
        checkOutput("t3_rsp_b_res", 32'(rsp_res), 255);
        nextCycle();
        checkOutput("t3_rsp_drop", 32'(rsp_vld), 0);
        checkOutput("t3_rsp_hold", 32'(rsp_res), 255);

        // MAXOUT limit: req1 held valid with args 1..5.
        expRdy = 14'b00_0000_1000_1111;
        for (int c = 0; c < 14; c++) begin
            expRsp[c] = 4'b0000;
            expRes[c] = 8'd0;
        end
        expRsp[6]  = 4'b0010; expRes[6]  = 8'd1;
        expRsp[7]  = 4'b0010; expRes[7]  = 8'd32;
        expRsp[8]  = 4'b0010; expRes[8]  = 8'd243;
        expRsp[9]  = 4'b0010; expRes[9]  = 8'd0;
        expRsp[13] = 4'b0010; expRes[13] = 8'd53;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            nextCycle();
            if (idx < 5) begin
                applyStimulus(4'b0010, 0, 8'(idx + 1), 0, 0);
            end else begin
                applyStimulus(4'b0000, 0, 0, 0, 0);
            end
            checkOutput($sformatf("t4_rdy_c%0d", c), 32'(req_rdy), 32'(expRdy[c]) << 1);
            checkOutput($sformatf("t4_rsp_c%0d", c), 32'(rsp_vld), 32'(expRsp[c]));
            if (expRsp[c] != 4'b0000) begin
                checkOutput($sformatf("t4_res_c%0d", c), 32'(rsp_res), 32'(expRes[c]));
            end
            if (req_rdy[1]) begin
                checkOutput($sformatf("t4_arg_c%0d", c), 32'(pipe_arg), idx + 1);
                idx++;
            end
        end
        checkOutput("t4_transfers", idx, 5);

        // Stray pipeline result sets err, which sticks until reset.
        nextCycle();
        checkOutput("t5_err_pre", 32'(err), 0);
        injectVld = 1'b1;
        #1;
        nextCycle();
        injectVld = 1'b0;
        #1;
        checkOutput("t5_err_set", 32'(err), 1);
        checkOutput("t5_no_rsp", 32'(rsp_vld), 0);
        nextCycle();
        nextCycle();
        checkOutput("t5_err_held", 32'(err), 1);
        doReset();
        checkOutput("t5_err_clr", 32'(err), 0);

        // Reset mid-flight: three transfers, reset two cycles later.
        applyStimulus(4'b1000, 0, 0, 0, 2);
        checkOutput("t6_rdy_a", 32'(req_rdy), 32'b1000);
        nextCycle();
        applyStimulus(4'b0100, 0, 0, 2, 0);
        checkOutput("t6_rdy_b", 32'(req_rdy), 32'b0100);
        nextCycle();
        applyStimulus(4'b0100, 0, 0, 2, 0);
        checkOutput("t6_rdy_c", 32'(req_rdy), 32'b0100);
        nextCycle();
        applyStimulus(4'b0000, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        applyStimulus(4'b1111, 1, 2, 3, 4);
        checkOutput("t6_rst_rdy", 32'(req_rdy), 0);
        checkOutput("t6_rst_issue", 32'(pipe_arg_vld), 0);
        checkOutput("t6_rst_rsp", 32'(rsp_vld), 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(4'b0000, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            checkOutput("t6_quiet_rsp", 32'(rsp_vld), 0);
        end
        checkOutput("t6_quiet_err", 32'(err), 0);
        applyStimulus(4'b1111, 1, 2, 3, 4);
        checkOutput("t6_regrant", 32'(req_rdy), 32'b0001);
        checkOutput("t6_regrant_arg", 32'(pipe_arg), 1);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(4'b0100, 0, 0, 3, 0);
            checkOutput("t6_req2_room", 32'(req_rdy), 32'b0100);
        end
        nextCycle();
        applyStimulus(4'b0000, 0, 0, 0, 0);
        repeat (8) nextCycle();
        checkOutput("t6_final_err", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
